keypad_scan: RTL and testbench

- 4x4 matrix keypad scanner with built-in debounce.
- Sits directly upstream of the code-lock controller and replaces the four slide switches plus separate debounced keys as the digit source.
- Drives one column low at a time, samples the rows, and emits one single-cycle key_valid pulse with a 4-bit key_code per debounced press.
- Tracks release so that a held key never repeats.

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/keypad_tick_gen.sv | 26 ++
 rtl/keypad_scan.sv | 134 +++++++++++++
 tb/tb_keypad_scan.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 keypad scanner.
//   state_t   - scanner FSM states
//   COL_RESET - column drive pattern after reset (column 0 low)
//   ROWS_IDLE - row pattern with no key pulling any row low
//   one_low() - true when exactly one bit of an active-low vector is low
//   low_idx() - index of the low bit in a one-hot-low vector
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  function automatic logic one_low(input logic [3:0] v);
    return ($countones(~v) == 1);
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 0; k < 4; k++)
      if (!v[k]) idx = k[1:0];
    return idx;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen: free-running divider producing the scan tick.
//   clk  - system clock
//   rst  - asynchronous reset, active-low
//   tick - one-cycle pulse every SCAN_DIV clocks (when divider == SCAN_DIV-1)
module keypad_tick_gen #(
  parameter int SCAN_DIV = 12000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div;

  assign tick = (div == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      div <= '0;
    else if (tick) div <= '0;
    else           div <= div + 1'b1;
  end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce and release tracking.
//   clk       - system clock
//   rst       - asynchronous reset, active-low
//   row[3:0]  - keypad rows, active-low, asynchronous to clk
//   col[3:0]  - column drive, one-hot-low
//   key_code  - last accepted key, {row_idx, col_idx}
//   key_valid - one-cycle pulse per accepted press
//   key_down  - high from acceptance until the release is accepted
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = 12000,
  parameter int DEB_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int CW = $clog2(DEB_TICKS + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_TICKS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic tick;

  keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchroniser; rows idle high so reset to all-ones.
  logic [3:0] row_s1, row_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1 <= ROWS_IDLE;
      row_s  <= ROWS_IDLE;
    end else begin
      row_s1 <= row;
      row_s  <= row_s1;
    end
  end

  state_t        state, state_n;
  logic [3:0]    col_n, row_lat, row_lat_n, code_n;
  logic [1:0]    col_idx, col_idx_n;
  logic [CW-1:0] deb_cnt, cnt_n;
  logic          valid_n, down_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SCAN;
      col       <= COL_RESET;
      row_lat   <= ROWS_IDLE;
      col_idx   <= 2'd0;
      deb_cnt   <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      row_lat   <= row_lat_n;
      col_idx   <= col_idx_n;
      deb_cnt   <= cnt_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_down  <= down_n;
    end
  end

  // Counting happens on ticks; acceptance of a full count (press or
  // release) is taken on the cycle after the count lands, which can never
  // itself be a tick since SCAN_DIV >= 2. Because a full count is always
  // consumed before the next tick, deb_cnt never passes DEB_TICKS.
  always_comb begin
    state_n   = state;
    col_n     = col;
    row_lat_n = row_lat;
    col_idx_n = col_idx;
    cnt_n     = deb_cnt;
    code_n    = key_code;
    valid_n   = 1'b0;
    down_n    = key_down;
    case (state)
      SCAN: begin
        if (tick) begin
          if (one_low(row_s)) begin
            row_lat_n = row_s;
            col_idx_n = low_idx(col);
            cnt_n     = CNT_ONE;
            state_n   = DEBOUNCE;
          end else begin
            col_n = {col[2:0], col[3]};
          end
        end
      end
      DEBOUNCE: begin
        if (deb_cnt == DEB_MAX) begin
          valid_n = 1'b1;
          code_n  = {low_idx(row_lat), col_idx};
          down_n  = 1'b1;
          state_n = HOLD;
        end else if (tick) begin
          if (row_s == row_lat) cnt_n   = deb_cnt + 1'b1;
          else                  state_n = SCAN;
        end
      end
      HOLD: begin
        // Extra keys in the held column keep rows low; only all-idle counts.
        if (tick && row_s == ROWS_IDLE) begin
          cnt_n   = CNT_ONE;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (deb_cnt == DEB_MAX) begin
          down_n  = 1'b0;
          state_n = SCAN;
        end else if (tick) begin
          if (row_s == ROWS_IDLE) cnt_n   = deb_cnt + 1'b1;
          else                    state_n = HOLD;
        end
      end
      default: state_n = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;

  localparam int SDIV = 4;
  localparam int DEB  = 3;

  logic       clk, rst;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_down;
  logic [15:0] keys;   // keys[r*4+c] = 1 means key (r,c) is pressed

  int checks, errors, npulse;

  keypad_scan #(.SCAN_DIV(SDIV), .DEB_TICKS(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Physical keypad: a pressed key shorts its row to its column.
  function automatic logic [3:0] rows_for(input logic [15:0] k, input logic [3:0] colv);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ~|(k[i*4 +: 4] & ~colv);
    return r;
  endfunction

  assign row = rows_for(keys, col);

  // ---------------- reference model ----------------
  // Scan position as an integer column, phase as a plain cycle counter,
  // and the keypad seen through the model's own column drive.
  localparam int M_SCAN = 0, M_DEB = 1, M_HOLD = 2, M_REL = 3;

  int         m_div = 0, m_ci = 0, m_mode = M_SCAN, m_cnt = 0, m_r = 0, m_c = 0;
  logic [3:0] m_code = 4'd0, m_s1 = 4'hF, m_s2 = 4'hF;
  logic       m_valid = 1'b0, m_down = 1'b0;
  bit         mtk;
  logic [3:0] mrs, mcolv, mpat, m_one;
  int         mr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_div <= 0; m_ci <= 0; m_mode <= M_SCAN; m_cnt <= 0; m_r <= 0; m_c <= 0;
      m_code <= 4'd0; m_s1 <= 4'hF; m_s2 <= 4'hF; m_valid <= 1'b0; m_down <= 1'b0;
    end else begin
      m_one = 4'b0001;
      mtk   = (m_div == SDIV - 1);
      mcolv = ~(m_one << m_ci);
      m_div <= mtk ? 0 : m_div + 1;
      m_s1  <= rows_for(keys, mcolv);
      m_s2  <= m_s1;
      mrs   = m_s2;
      m_valid <= 1'b0;
      case (m_mode)
        M_SCAN:
          if (mtk) begin
            if ($countones(mrs) == 3) begin
              mr = 0;
              for (int i = 0; i < 4; i++) if (!mrs[i]) mr = i;
              m_r <= mr; m_c <= m_ci; m_cnt <= 1; m_mode <= M_DEB;
            end else m_ci <= (m_ci + 1) % 4;
          end
        M_DEB: begin
          mpat = ~(m_one << m_r);
          if (m_cnt == DEB) begin
            m_valid <= 1'b1; m_code <= 4'(m_r * 4 + m_c); m_down <= 1'b1; m_mode <= M_HOLD;
          end else if (mtk) begin
            if (mrs == mpat) m_cnt <= m_cnt + 1;
            else             m_mode <= M_SCAN;
          end
        end
        M_HOLD:
          if (mtk && mrs == 4'hF) begin m_cnt <= 1; m_mode <= M_REL; end
        default:
          if (m_cnt == DEB) begin m_down <= 1'b0; m_mode <= M_SCAN; end
          else if (mtk) begin
            if (mrs == 4'hF) m_cnt <= m_cnt + 1;
            else             m_mode <= M_HOLD;
          end
      endcase
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // One clock: compare DUT to model at the falling edge, then return 2ns
  // later so stimulus changes land well away from both edges.
  task automatic cyc();
    logic [3:0] one, ecol;
    @(negedge clk);
    one  = 4'b0001;
    ecol = ~(one << m_ci);
    chk("model", {20'd0, col, key_valid, key_down, key_code},
                 {20'd0, ecol, m_valid, m_down, m_code});
    if (key_valid) npulse++;
    #2;
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      cyc();
      if (key_valid) ok = 1'b1;
    end
  endtask

  task automatic wait_fall(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      cyc();
      if (!key_down) ok = 1'b1;
    end
  endtask

  task automatic wait_col(input logic [3:0] c, input bit eq, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      cyc();
      if ((col == c) == eq) ok = 1'b1;
    end
  endtask

  initial begin
    int p0;
    bit ok;
    logic [3:0] c0;
    rst = 1'b0; keys = 16'd0; checks = 0; errors = 0; npulse = 0;

    // Reset values
    repeat (3) cyc();
    chk("rst_col", col, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_down", key_down, 0);
    chk("rst_code", key_code, 0);
    rst = 1'b1;

    // Idle scanning: one rotation per 4 clocks, no pulses
    p0 = npulse;
    repeat (3) cyc();
    c0 = col;
    repeat (4) cyc();
    chk("idle_rotate", col, {c0[2:0], c0[3]});
    repeat (20) cyc();
    chk("idle_pulses", npulse - p0, 0);
    chk("idle_down", key_down, 0);

    // Row1/col2 held: one pulse, code 6, within the latency bound
    keys[6] = 1'b1;
    p0 = npulse;
    wait_valid(31, ok);
    chk("k6_latency", ok, 1);
    chk("k6_code", key_code, 6);
    chk("k6_down", key_down, 1);
    repeat (40) cyc();
    chk("k6_once", npulse - p0, 1);
    keys = 16'd0;
    wait_fall(30, ok);
    chk("k6_release", ok, 1);
    repeat (8) cyc();
    c0 = col;
    repeat (4) cyc();
    chk("k6_rescan", col, {c0[2:0], c0[3]});

    // Row3/col0 for one tick only: no pulse, code unchanged
    wait_col(4'b1110, 1'b0, 20, ok);
    wait_col(4'b1110, 1'b1, 20, ok);
    chk("short_align", ok, 1);
    keys[12] = 1'b1;
    p0 = npulse;
    repeat (4) cyc();
    keys = 16'd0;
    repeat (30) cyc();
    chk("short_pulses", npulse - p0, 0);
    chk("short_code", key_code, 6);
    chk("short_down", key_down, 0);

    // Rows 0 and 2 in col1 together: ambiguous, ignored
    keys[1] = 1'b1; keys[9] = 1'b1;
    p0 = npulse;
    repeat (20) cyc();
    c0 = col;
    repeat (4) cyc();
    chk("multi_rotate", col, {c0[2:0], c0[3]});
    repeat (16) cyc();
    chk("multi_pulses", npulse - p0, 0);
    keys = 16'd0;
    repeat (8) cyc();

    // Key 3 held, then key 11 added in the same column: one pulse
    keys[3] = 1'b1;
    p0 = npulse;
    wait_valid(31, ok);
    chk("k3_seen", ok, 1);
    chk("k3_code", key_code, 3);
    repeat (8) cyc();
    keys[11] = 1'b1;
    repeat (30) cyc();
    chk("k3_held", key_down, 1);
    keys = 16'd0;
    wait_fall(30, ok);
    chk("k3_release", ok, 1);
    chk("k3_once", npulse - p0, 1);
    chk("k3_code_kept", key_code, 3);

    // Reset while debouncing key 5, then a fresh full debounce
    repeat (6) cyc();
    keys[5] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cyc();
      if (m_mode == M_DEB) ok = 1'b1;
    end
    chk("deb_reached", ok, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_col", col, 4'b1110);
    chk("mid_rst_down", key_down, 0);
    chk("mid_rst_valid", key_valid, 0);
    repeat (2) cyc();
    rst = 1'b1;
    p0 = npulse;
    repeat (12) cyc();
    chk("post_rst_quiet", npulse - p0, 0);
    wait_valid(30, ok);
    chk("k5_seen", ok, 1);
    chk("k5_code", key_code, 5);
    keys = 16'd0;
    wait_fall(30, ok);
    chk("k5_release", ok, 1);
    repeat (5) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
